// File: rtl/hamming_pkg.sv
// hamming_pkg: shared FSM state encoding, widths and the SECDED encode function
// Exports: state_t, CW_W, MSG_W, hamming_enc(msg[10:0]) -> codeword[15:0]
package hamming_pkg;
    localparam int CW_W = 16;
    localparam int MSG_W = 11;
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;
    function automatic logic [CW_W-1:0] hamming_enc(input logic [MSG_W-1:0] m);
        logic [11:1] d;
        logic p8, p4, p2, p1, p0;
        d = m;
        p8 = ^d[11:5];
        p4 = ^{d[11:8], d[4:2]};
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = ^d ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction
endpackage

// File: rtl/hamming_enc_seq_if.sv
// hamming_enc_seq_if: start/done handshake plus 8-bit data-memory port of the sequencer
// master: sequencer side (drives done, busy, mem_addr, mem_wr_en, mem_wdata)
// slave:  host/memory side (drives req, mem_rdata)
interface hamming_enc_seq_if #(parameter int AW = 8);
    logic          req;
    logic          done;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    modport master (input req, mem_rdata, output done, busy, mem_addr, mem_wr_en, mem_wdata);
    modport slave (output req, mem_rdata, input done, busy, mem_addr, mem_wr_en, mem_wdata);
endinterface

// File: rtl/hamming_enc_core.sv
// hamming_enc_core: combinational 11-bit message to 16-bit SECDED codeword encoder
// msg_i: message bits d[11:1]; cw_o: codeword {d[11:5],p8,d[4:2],p4,d1,p2,p1,p0}
module hamming_enc_core
    import hamming_pkg::*;
(
    input  logic [MSG_W-1:0] msg_i,
    output logic [CW_W-1:0]  cw_o
);
    assign cw_o = hamming_enc(msg_i);
endmodule

// File: rtl/hamming_enc_seq.sv
// hamming_enc_seq: memory-mastering sequencer that SECDED-encodes NUM_MSG messages
// clk: rising-edge clock; reset: async active-low
// bus (master): req rising edge starts a job; done sticky; busy during job;
//               mem_addr/mem_wr_en/mem_wdata drive the data memory, mem_rdata is its combinational read
module hamming_enc_seq
    import hamming_pkg::*;
#(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
)
(
    input logic               clk,
    input logic               reset,
    hamming_enc_seq_if.master bus
);
    state_t          state_q, state_d;
    logic [6:0]      i_q, i_d;
    logic [7:0]      lo_q, lo_d;
    logic [2:0]      hi_q, hi_d;
    logic            req_q, done_q, done_d;
    logic [CW_W-1:0] cw;
    logic [AW-1:0]   src_a, dst_a;
    logic            start, last;

    hamming_enc_core u_core (.msg_i({hi_q, lo_q}), .cw_o(cw));

    // byte-pair addresses wrap modulo 2^AW
    assign src_a = AW'(SRC_BASE + 2 * int'(i_q));
    assign dst_a = AW'(DST_BASE + 2 * int'(i_q));
    assign start = bus.req && !req_q && (state_q == IDLE || state_q == DONE);
    assign last = i_q == 7'(NUM_MSG - 1);
    assign bus.done = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            req_q   <= bus.req;
            done_q  <= done_d;
        end
    end

    // done is registered off the DONE state, so it rises one edge after DONE is entered
    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        done_d        = start ? 1'b0 : (state_q == DONE) ? 1'b1 : done_q;
        bus.busy      = 1'b0;
        bus.mem_wr_en = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            IDLE, DONE: begin
                state_d = start ? RD_LO : state_q;
                i_d     = start ? '0 : i_q;
            end
            RD_LO: begin
                bus.busy     = 1'b1;
                bus.mem_addr = src_a;
                lo_d         = bus.mem_rdata;
                state_d      = RD_HI;
            end
            RD_HI: begin
                bus.busy     = 1'b1;
                bus.mem_addr = src_a + AW'(1);
                hi_d         = bus.mem_rdata[2:0];
                state_d      = WR_LO;
            end
            WR_LO: begin
                bus.busy      = 1'b1;
                bus.mem_addr  = dst_a;
                bus.mem_wr_en = 1'b1;
                bus.mem_wdata = cw[7:0];
                state_d       = WR_HI;
            end
            WR_HI: begin
                bus.busy      = 1'b1;
                bus.mem_addr  = dst_a + AW'(1);
                bus.mem_wr_en = 1'b1;
                bus.mem_wdata = cw[15:8];
                state_d       = last ? DONE : RD_LO;
                i_d           = last ? i_q : i_q + 7'd1;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_hamming_enc_seq.sv
// tb_hamming_enc_seq: directed checks of the Hamming encode sequencer against a positional Hamming model
module tb_hamming_enc_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          bad_wr = 0;
    logic [7:0]  mem_a [256];
    logic [7:0]  mem_b [256];
    logic [7:0]  lo_v [15];
    logic [7:0]  hi_v [15];
    logic [15:0] exp_d [5];

    hamming_enc_seq_if #(.AW(8)) ifa ();
    hamming_enc_seq_if #(.AW(8)) ifb ();

    hamming_enc_seq #(.NUM_MSG(15), .SRC_BASE(0), .DST_BASE(30), .AW(8)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    hamming_enc_seq #(.NUM_MSG(2), .SRC_BASE(100), .DST_BASE(254), .AW(8)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    always #5 clk = ~clk;
    assign ifa.mem_rdata = mem_a[ifa.mem_addr];
    assign ifb.mem_rdata = mem_b[ifb.mem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // classic positional Hamming(15,11): data in non-power-of-two slots, parity at 1,2,4,8, overall at 0
    function automatic logic [15:0] ref_cw(input logic [10:0] m);
        logic [15:0] c;
        logic        b;
        int          k;
        c = '0;
        k = 0;
        for (int p = 3; p < 16; p++)
            if ((p & (p - 1)) != 0) begin
                c[p] = m[k];
                k++;
            end
        for (int j = 0; j < 4; j++) begin
            b = 1'b0;
            for (int p = 3; p < 16; p++)
                if (((p >> j) & 1) == 1) b = b ^ c[p];
            c[1 << j] = b;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    // one cycle: wait for the falling edge, then commit any memory write the DUTs present
    task automatic tick();
        @(negedge clk);
        if (ifa.mem_wr_en) begin
            mem_a[ifa.mem_addr] = ifa.mem_wdata;
            if (ifa.mem_addr < 8'd30 || ifa.mem_addr > 8'd59) bad_wr++;
        end
        if (ifb.mem_wr_en) mem_b[ifb.mem_addr] = ifb.mem_wdata;
    endtask

    task automatic run_a(input int drop_at, output logic [1:0] st0, output int edges, output int busy_n);
        bad_wr = 0;
        edges = 0;
        ifa.req = 1'b1;
        tick();
        st0 = {ifa.done, ifa.busy};
        busy_n = int'(ifa.busy);
        for (int e = 1; e <= 200; e++) begin
            if (e == drop_at) ifa.req = 1'b0;
            tick();
            busy_n += int'(ifa.busy);
            if (ifa.done) begin
                edges = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        ifa.req = 1'b0;
        ifb.req = 1'b0;
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 8'h00;
            mem_b[k] = 8'h00;
        end
        reset = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({ifa.done, ifa.busy, ifa.mem_wr_en, ifa.mem_addr, ifa.mem_wdata} !== 19'd0)
            $display("FAIL reset_a: outputs=%h expected 0", {ifa.done, ifa.busy, ifa.mem_wr_en, ifa.mem_addr, ifa.mem_wdata});
        else pass_cnt++;
        total_cnt++;
        if ({ifb.done, ifb.busy, ifb.mem_wr_en, ifb.mem_addr, ifb.mem_wdata} !== 19'd0)
            $display("FAIL reset_b: outputs=%h expected 0", {ifb.done, ifb.busy, ifb.mem_wr_en, ifb.mem_addr, ifb.mem_wdata});
        else pass_cnt++;
        reset = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({ifa.done, ifa.busy, ifa.mem_wr_en} !== 3'b000)
            $display("FAIL idle_after_reset: done/busy/wr=%b expected 000", {ifa.done, ifa.busy, ifa.mem_wr_en});
        else pass_cnt++;
    endtask

    task automatic test_encode();
        logic [1:0] st0;
        int         edges, busy_n;
        lo_v[0] = 8'hFF; hi_v[0] = 8'h07;
        lo_v[1] = 8'h01; hi_v[1] = 8'h00;
        lo_v[2] = 8'h00; hi_v[2] = 8'h04;
        lo_v[3] = 8'h00; hi_v[3] = 8'h00;
        lo_v[4] = 8'h00; hi_v[4] = 8'hFC;
        exp_d[0] = 16'hFFFF; exp_d[1] = 16'h000F; exp_d[2] = 16'h8117; exp_d[3] = 16'h0000; exp_d[4] = 16'h8117;
        for (int k = 5; k < 15; k++) begin
            lo_v[k] = 8'($urandom_range(0, 255));
            hi_v[k] = 8'($urandom_range(0, 255));
        end
        for (int k = 0; k < 15; k++) begin
            mem_a[2 * k] = lo_v[k];
            mem_a[2 * k + 1] = hi_v[k];
        end
        for (int k = 30; k < 60; k++) mem_a[k] = 8'hA5;
        run_a(0, st0, edges, busy_n);
        total_cnt++;
        if (st0 !== 2'b01) $display("FAIL enc_start: done,busy=%b expected 01", st0); else pass_cnt++;
        total_cnt++;
        if (edges !== 61) $display("FAIL enc_latency: done after %0d edges expected 61", edges); else pass_cnt++;
        total_cnt++;
        if (busy_n !== 60) $display("FAIL enc_busy: busy cycles=%0d expected 60", busy_n); else pass_cnt++;
        total_cnt++;
        if (bad_wr !== 0) $display("FAIL enc_stray_writes: count=%0d expected 0", bad_wr); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            total_cnt++;
            if ({mem_a[31 + 2 * k], mem_a[30 + 2 * k]} !== exp_d[k])
                $display("FAIL enc_directed[%0d]: got %h expected %h", k, {mem_a[31 + 2 * k], mem_a[30 + 2 * k]}, exp_d[k]);
            else pass_cnt++;
        end
        for (int k = 0; k < 15; k++) begin
            total_cnt++;
            if ({mem_a[31 + 2 * k], mem_a[30 + 2 * k]} !== ref_cw({hi_v[k][2:0], lo_v[k]}))
                $display("FAIL enc_cw[%0d]: got %h expected %h", k, {mem_a[31 + 2 * k], mem_a[30 + 2 * k]}, ref_cw({hi_v[k][2:0], lo_v[k]}));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_job();
        logic [1:0] st0;
        int         edges, busy_n;
        logic [15:0] c2;
        c2 = ref_cw({hi_v[2][2:0], lo_v[2]});
        for (int k = 30; k < 60; k++) mem_a[k] = 8'hA5;
        ifa.req = 1'b0;
        tick();
        ifa.req = 1'b1;
        tick();
        for (int k = 0; k < 13; k++) tick();
        @(posedge clk);
        #1;
        total_cnt++;
        if ({ifa.mem_wr_en, ifa.mem_addr} !== {1'b1, 8'd36})
            $display("FAIL mid_in_wr_lo: wr,addr=%b,%0d expected 1,36", ifa.mem_wr_en, ifa.mem_addr);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({ifa.done, ifa.busy, ifa.mem_wr_en, ifa.mem_addr, ifa.mem_wdata} !== 19'd0)
            $display("FAIL mid_reset_outputs: %h expected 0", {ifa.done, ifa.busy, ifa.mem_wr_en, ifa.mem_addr, ifa.mem_wdata});
        else pass_cnt++;
        ifa.req = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (mem_a[36] !== 8'hA5) $display("FAIL mid_mem36: got %h expected a5", mem_a[36]); else pass_cnt++;
        total_cnt++;
        if ({mem_a[35], mem_a[34]} !== c2) $display("FAIL mid_msg2_kept: got %h expected %h", {mem_a[35], mem_a[34]}, c2); else pass_cnt++;
        reset = 1'b1;
        tick();
        tick();
        run_a(0, st0, edges, busy_n);
        total_cnt++;
        if (edges !== 61) $display("FAIL mid_rerun_latency: %0d edges expected 61", edges); else pass_cnt++;
        total_cnt++;
        if (bad_wr !== 0) $display("FAIL mid_rerun_stray: count=%0d expected 0", bad_wr); else pass_cnt++;
        for (int k = 0; k < 15; k++) begin
            total_cnt++;
            if ({mem_a[31 + 2 * k], mem_a[30 + 2 * k]} !== ref_cw({hi_v[k][2:0], lo_v[k]}))
                $display("FAIL mid_rerun_cw[%0d]: got %h expected %h", k, {mem_a[31 + 2 * k], mem_a[30 + 2 * k]}, ref_cw({hi_v[k][2:0], lo_v[k]}));
            else pass_cnt++;
        end
    endtask

    task automatic test_req_held();
        logic [1:0] st0;
        int         edges, busy_n;
        for (int k = 0; k < 8; k++) begin
            tick();
            total_cnt++;
            if ({ifa.done, ifa.busy} !== 2'b10) $display("FAIL held_no_restart[%0d]: done,busy=%b expected 10", k, {ifa.done, ifa.busy});
            else pass_cnt++;
        end
        for (int k = 30; k < 60; k++) mem_a[k] = 8'hA5;
        ifa.req = 1'b0;
        tick();
        total_cnt++;
        if (ifa.done !== 1'b1) $display("FAIL held_done_sticky: done=%b expected 1", ifa.done); else pass_cnt++;
        run_a(5, st0, edges, busy_n);
        total_cnt++;
        if (st0 !== 2'b01) $display("FAIL held_restart: done,busy=%b expected 01", st0); else pass_cnt++;
        total_cnt++;
        if (edges !== 61) $display("FAIL held_latency: %0d edges expected 61", edges); else pass_cnt++;
        total_cnt++;
        if (busy_n !== 60) $display("FAIL held_busy: busy cycles=%0d expected 60", busy_n); else pass_cnt++;
        for (int k = 0; k < 15; k++) begin
            total_cnt++;
            if ({mem_a[31 + 2 * k], mem_a[30 + 2 * k]} !== ref_cw({hi_v[k][2:0], lo_v[k]}))
                $display("FAIL held_cw[%0d]: got %h expected %h", k, {mem_a[31 + 2 * k], mem_a[30 + 2 * k]}, ref_cw({hi_v[k][2:0], lo_v[k]}));
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        int edges;
        edges = 0;
        mem_b[100] = 8'hFF; mem_b[101] = 8'h07;
        mem_b[102] = 8'h00; mem_b[103] = 8'h04;
        ifb.req = 1'b1;
        tick();
        for (int e = 1; e <= 50; e++) begin
            tick();
            if (ifb.done) begin
                edges = e;
                break;
            end
        end
        total_cnt++;
        if (edges !== 9) $display("FAIL wrap_latency: %0d edges expected 9", edges); else pass_cnt++;
        total_cnt++;
        if ({mem_b[255], mem_b[254]} !== 16'hFFFF) $display("FAIL wrap_cw0: got %h expected ffff", {mem_b[255], mem_b[254]}); else pass_cnt++;
        total_cnt++;
        if ({mem_b[1], mem_b[0]} !== 16'h8117) $display("FAIL wrap_cw1: got %h expected 8117", {mem_b[1], mem_b[0]}); else pass_cnt++;
        total_cnt++;
        if ({mem_b[253], mem_b[2]} !== 16'h0000) $display("FAIL wrap_neighbours: got %h expected 0000", {mem_b[253], mem_b[2]}); else pass_cnt++;
        ifb.req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_encode();
        test_reset_mid_job();
        test_req_held();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
